// File: rtl/id_issue_q_pkg.sv
// Shared RV32I decode constants and types for the decode/issue stage.
package id_issue_q_pkg;

    localparam int OPCODE_W = 11;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [OPCODE_W-1:0] NOP_OPCODE = '0;
    localparam logic                NOP_WREG   = 1'b0;
    localparam logic [31:0]         ZeroWord   = '0;
    localparam logic [4:0]          NOPRegAddr = '0;

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] inst;
    } q_entry_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/id_issue_q_if.sv
// Fetch-to-decode handshake bundle.
interface id_issue_q_if;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_taken;

    modport master (output if_valid, if_pc, if_inst, if_taken, input if_ready);
    modport slave  (input if_valid, if_pc, if_inst, if_taken, output if_ready);

endinterface

// File: rtl/id_issue_q_inst_fifo.sv
// Instruction queue: power-of-two ring buffer with combinational head.
module inst_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Callers never push when full nor pop when empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/id_issue_q.sv
// RV32I decode/issue stage: instruction queue, head decode, forwarding,
// load-use interlock and a registered valid/ready output slot.
module id_issue_q
    import id_issue_q_pkg::*;
#(
    parameter int QDEPTH    = 4,
    parameter int NUM_FWD   = 3,
    parameter int NUM_LDSTG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     flush,
    id_issue_q_if.slave              fetch,
    output logic [4:0]               rs1_addr,
    output logic [4:0]               rs2_addr,
    input  logic [31:0]              rs1_data,
    input  logic [31:0]              rs2_data,
    input  logic [NUM_FWD-1:0]       fwd_wreg,
    input  logic [5*NUM_FWD-1:0]     fwd_wd,
    input  logic [32*NUM_FWD-1:0]    fwd_wdata,
    input  logic [NUM_LDSTG-1:0]     ld_busy,
    input  logic [5*NUM_LDSTG-1:0]   ld_rd,
    input  logic                     ex_ready,
    output logic                     id_valid,
    output logic [OPCODE_W-1:0]      opcode_o,
    output logic [31:0]              reg1_o,
    output logic [31:0]              reg2_o,
    output logic [31:0]              imm_o,
    output logic [4:0]               wd_o,
    output logic                     wreg_o,
    output logic [31:0]              br_t_o,
    output logic [31:0]              br_n_o,
    output logic                     taken_o,
    output logic                     b_we_o,
    output logic [31:0]              b_waddr_o,
    output logic [31:0]              b_wtarget_o
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [CW-1:0] count;
    q_entry_t      head_e;
    logic          push, pop, hazard;

    assign fetch.if_ready = (count < CW'(QDEPTH));
    assign push = rdy && !flush && fetch.if_valid && fetch.if_ready;
    assign pop  = rdy && !flush && ex_ready && (count != '0) && !hazard;

    inst_fifo #(
        .WIDTH ($bits(q_entry_t)),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (rdy && flush),
        .din   ({fetch.if_taken, fetch.if_pc, fetch.if_inst}),
        .head  (head_e),
        .count (count)
    );

    logic [31:0] inst, pc;
    logic [6:0]  opc;
    logic [4:0]  rs1, rs2, rd;

    assign inst     = head_e.inst;
    assign pc       = head_e.pc;
    assign opc      = inst[6:0];
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];
    assign rd       = inst[11:7];
    assign rs1_addr = rs1;
    assign rs2_addr = rs2;

    // Lowest-index matching channel wins; x0 always reads as zero.
    function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rf);
        logic [31:0] r;
        logic        hit;
        r   = rf;
        hit = 1'b0;
        if (a == NOPRegAddr) begin
            r = ZeroWord;
        end else begin
            for (int unsigned i = 0; i < NUM_FWD; i++) begin
                if (!hit && fwd_wreg[i] && fwd_wd[5*i +: 5] == a) begin
                    r   = fwd_wdata[32*i +: 32];
                    hit = 1'b1;
                end
            end
        end
        return r;
    endfunction

    logic                rd1, rd2, known, wr;
    logic [31:0]         src1, src2, dec_imm, dec_op1, dec_op2, dec_bt, dec_bn;
    logic [OPCODE_W-1:0] dec_opcode;
    logic [4:0]          dec_wd;
    logic                dec_wreg, is_btb;

    always_comb begin
        src1    = resolve(rs1, rs1_data);
        src2    = resolve(rs2, rs2_data);
        rd1     = 1'b0;
        rd2     = 1'b0;
        wr      = 1'b0;
        known   = 1'b1;
        dec_imm = ZeroWord;
        dec_bt  = ZeroWord;
        dec_bn  = ZeroWord;
        case (opc)
            OP_OP:    begin rd1 = 1'b1; rd2 = 1'b1; wr = 1'b1; end
            OP_IMM:   begin rd1 = 1'b1; wr = 1'b1; dec_imm = sext12(inst[31:20]); end
            OP_LUI:   begin wr = 1'b1; dec_imm = {inst[31:12], 12'b0}; end
            OP_AUIPC: begin wr = 1'b1; dec_imm = pc + {inst[31:12], 12'b0}; end
            OP_JAL: begin
                wr      = 1'b1;
                dec_imm = pc + 32'd4;
                dec_bt  = pc + {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                dec_bn  = pc + 32'd4;
            end
            OP_JALR: begin
                rd1     = 1'b1;
                wr      = 1'b1;
                dec_imm = pc + 32'd4;
                dec_bt  = src1 + sext12(inst[31:20]);
                dec_bn  = pc + 32'd4;
            end
            OP_BRANCH: begin
                rd1     = 1'b1;
                rd2     = 1'b1;
                dec_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                dec_bt  = pc + dec_imm;
                dec_bn  = pc + 32'd4;
            end
            OP_LOAD:  begin rd1 = 1'b1; wr = 1'b1; dec_imm = sext12(inst[31:20]); end
            OP_STORE: begin rd1 = 1'b1; rd2 = 1'b1; dec_imm = sext12({inst[31:25], inst[11:7]}); end
            default:  known = 1'b0;
        endcase
        dec_opcode = known ? {inst[30], inst[14:12], inst[6:0]} : NOP_OPCODE;
        dec_op1    = rd1 ? src1 : dec_imm;
        dec_op2    = rd2 ? src2 : dec_imm;
        dec_wreg   = known ? (wr && rd != NOPRegAddr) : NOP_WREG;
        dec_wd     = (known && wr) ? rd : NOPRegAddr;
        is_btb     = (opc == OP_JAL) || (opc == OP_BRANCH);
    end

    function automatic logic reads_reg(input logic [4:0] a);
        return (a != NOPRegAddr) && ((rd1 && rs1 == a) || (rd2 && rs2 == a));
    endfunction

    // Slot check covers the load that has not yet reached a busy-reporting stage.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < NUM_LDSTG; i++) begin
            if (ld_busy[i] && reads_reg(ld_rd[5*i +: 5])) hazard = 1'b1;
        end
        if (id_valid && opcode_o[6:0] == OP_LOAD && reads_reg(wd_o)) hazard = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid  <= 1'b0;
            opcode_o  <= '0;
            reg1_o    <= '0;
            reg2_o    <= '0;
            imm_o     <= '0;
            wd_o      <= '0;
            wreg_o    <= 1'b0;
            br_t_o    <= '0;
            br_n_o    <= '0;
            taken_o   <= 1'b0;
            b_we_o    <= 1'b0;
            b_waddr_o <= '0;
        end else if (rdy) begin
            if (flush) begin
                id_valid <= 1'b0;
                b_we_o   <= 1'b0;
            end else begin
                b_we_o <= pop && is_btb;
                if (pop) begin
                    id_valid  <= 1'b1;
                    opcode_o  <= dec_opcode;
                    reg1_o    <= dec_op1;
                    reg2_o    <= dec_op2;
                    imm_o     <= dec_imm;
                    wd_o      <= dec_wd;
                    wreg_o    <= dec_wreg;
                    br_t_o    <= dec_bt;
                    br_n_o    <= dec_bn;
                    taken_o   <= head_e.taken;
                    b_waddr_o <= head_e.pc;
                end else if (ex_ready) begin
                    id_valid <= 1'b0;
                end
            end
        end
    end

    assign b_wtarget_o = br_t_o;

endmodule

// File: tb/tb_id_issue_q.sv
// Directed bench for id_issue_q: decode vector table plus multi-cycle sequences.
module tb_id_issue_q;

    logic         clk = 1'b0;
    logic         rst_n, rdy, flush, ex_ready;
    logic [4:0]   rs1_addr, rs2_addr;
    logic [31:0]  rs1_data, rs2_data;
    logic [2:0]   fwd_wreg;
    logic [14:0]  fwd_wd;
    logic [95:0]  fwd_wdata;
    logic [0:0]   ld_busy;
    logic [4:0]   ld_rd;
    logic         id_valid, wreg_o, taken_o, b_we_o;
    logic [10:0]  opcode_o;
    logic [31:0]  reg1_o, reg2_o, imm_o, br_t_o, br_n_o, b_waddr_o, b_wtarget_o;
    logic [4:0]   wd_o;

    id_issue_q_if fif ();

    id_issue_q #(.QDEPTH(4), .NUM_FWD(3), .NUM_LDSTG(1)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .fetch(fif),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata),
        .ld_busy(ld_busy), .ld_rd(ld_rd), .ex_ready(ex_ready),
        .id_valid(id_valid), .opcode_o(opcode_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .imm_o(imm_o), .wd_o(wd_o), .wreg_o(wreg_o), .br_t_o(br_t_o), .br_n_o(br_n_o),
        .taken_o(taken_o), .b_we_o(b_we_o), .b_waddr_o(b_waddr_o), .b_wtarget_o(b_wtarget_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, inst, d1, d2;
        logic [10:0] opc;
        logic [31:0] r1, r2, imm;
        logic [4:0]  wd;
        logic        wreg;
        logic        chk_br;
        logic [31:0] bt, bn;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
        fif.if_pc    = pc;
        fif.if_inst  = inst;
        fif.if_valid = 1'b1;
        tick();
        fif.if_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        //          pc            inst          d1            d2            opc       r1            r2            imm           wd     wr    br    bt            bn
        vt[0]  = '{32'h0000_0000, 32'h0050_0093, 32'h100, 32'h20, 11'h013, 32'h0,        32'h5,        32'h5,        5'd0+5'd1, 1'b1, 1'b0, 32'h0,   32'h0};
        vt[1]  = '{32'h0000_0004, 32'h0020_81B3, 32'h100, 32'h20, 11'h033, 32'h100,      32'h20,       32'h0,        5'd3, 1'b1, 1'b0, 32'h0,   32'h0};
        vt[2]  = '{32'h0000_0008, 32'h4020_8233, 32'h100, 32'h20, 11'h433, 32'h100,      32'h20,       32'h0,        5'd4, 1'b1, 1'b0, 32'h0,   32'h0};
        vt[3]  = '{32'h0000_000C, 32'h1234_52B7, 32'h100, 32'h20, 11'h2B7, 32'h1234_5000, 32'h1234_5000, 32'h1234_5000, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0};
        vt[4]  = '{32'h0000_0200, 32'h0000_1317, 32'h100, 32'h20, 11'h097, 32'h1200,     32'h1200,     32'h1200,     5'd6, 1'b1, 1'b0, 32'h0,   32'h0};
        vt[5]  = '{32'h0000_0300, 32'hFFC0_A383, 32'h100, 32'h20, 11'h503, 32'h100,      32'hFFFF_FFFC, 32'hFFFF_FFFC, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0};
        vt[6]  = '{32'h0000_0304, 32'h0020_A423, 32'h100, 32'h20, 11'h123, 32'h100,      32'h20,       32'h8,        5'd0, 1'b0, 1'b0, 32'h0,   32'h0};
        vt[7]  = '{32'h0000_0400, 32'h0020_8463, 32'h100, 32'h20, 11'h063, 32'h100,      32'h20,       32'h8,        5'd0, 1'b0, 1'b1, 32'h408, 32'h404};
        vt[8]  = '{32'h0000_0500, 32'h00C2_80E7, 32'h101, 32'h20, 11'h067, 32'h101,      32'h504,      32'h504,      5'd1, 1'b1, 1'b1, 32'h10D, 32'h504};
        vt[9]  = '{32'h0000_0504, 32'h0010_0013, 32'h100, 32'h20, 11'h013, 32'h0,        32'h1,        32'h1,        5'd0, 1'b0, 1'b0, 32'h0,   32'h0};
        vt[10] = '{32'h0000_0508, 32'h4030_D413, 32'h100, 32'h20, 11'h693, 32'h100,      32'h403,      32'h403,      5'd8, 1'b1, 1'b0, 32'h0,   32'h0};
        vt[11] = '{32'h0000_050C, 32'hFFFF_FFFF, 32'h100, 32'h20, 11'h000, 32'h0,        32'h0,        32'h0,        5'd0, 1'b0, 1'b0, 32'h0,   32'h0};
        vt[12] = '{32'h0000_0600, 32'hFE20_9EE3, 32'h100, 32'h20, 11'h4E3, 32'h100,      32'h20,       32'hFFFF_FFFC, 5'd0, 1'b0, 1'b1, 32'h5FC, 32'h604};

        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        rs1_data = '0; rs2_data = '0; fwd_wreg = '0; fwd_wd = '0; fwd_wdata = '0;
        ld_busy = '0; ld_rd = '0;
        fif.if_valid = 1'b0; fif.if_pc = '0; fif.if_inst = '0; fif.if_taken = 1'b0;
        tick();
        tick();
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_b_we", 32'(b_we_o), 32'd0);
        chk("rst_opcode", 32'(opcode_o), 32'd0);
        chk("rst_reg1", reg1_o, 32'd0);
        chk("rst_imm", imm_o, 32'd0);
        chk("rst_wd", 32'(wd_o), 32'd0);
        chk("rst_if_ready", 32'(fif.if_ready), 32'd1);
        rst_n = 1'b1;

        // Decode table: push, one edge later the head sits in the slot, then a bubble.
        for (int k = 0; k < NV; k++) begin
            rs1_data = vt[k].d1;
            rs2_data = vt[k].d2;
            push_one(vt[k].pc, vt[k].inst);
            chk($sformatf("v%0d_latency", k), 32'(id_valid), 32'd0);
            tick();
            chk($sformatf("v%0d_valid", k), 32'(id_valid), 32'd1);
            chk($sformatf("v%0d_opcode", k), 32'(opcode_o), 32'(vt[k].opc));
            chk($sformatf("v%0d_reg1", k), reg1_o, vt[k].r1);
            chk($sformatf("v%0d_reg2", k), reg2_o, vt[k].r2);
            chk($sformatf("v%0d_imm", k), imm_o, vt[k].imm);
            chk($sformatf("v%0d_wd", k), 32'(wd_o), 32'(vt[k].wd));
            chk($sformatf("v%0d_wreg", k), 32'(wreg_o), 32'(vt[k].wreg));
            if (vt[k].chk_br) begin
                chk($sformatf("v%0d_br_t", k), br_t_o, vt[k].bt);
                chk($sformatf("v%0d_br_n", k), br_n_o, vt[k].bn);
            end
            tick();
        end

        // Load-use: LW x2,0(x1) then ADD x3,x2,x2.
        rs1_data = 32'h100; rs2_data = 32'h20;
        fif.if_valid = 1'b1; fif.if_pc = 32'h10; fif.if_inst = 32'h0000_A103;
        tick();
        fif.if_pc = 32'h14; fif.if_inst = 32'h0021_01B3;
        tick();
        fif.if_valid = 1'b0;
        chk("lu_lw_valid", 32'(id_valid), 32'd1);
        chk("lu_lw_opcode", 32'(opcode_o), 32'h103);
        tick();
        chk("lu_slot_bubble", 32'(id_valid), 32'd0);
        ld_busy = 1'b1; ld_rd = 5'd2;
        tick();
        chk("lu_busy_bubble1", 32'(id_valid), 32'd0);
        tick();
        chk("lu_busy_bubble2", 32'(id_valid), 32'd0);
        ld_busy = 1'b0;
        fwd_wreg = 3'b001; fwd_wd = {5'd0, 5'd0, 5'd2}; fwd_wdata = {32'h0, 32'h0, 32'h77};
        tick();
        chk("lu_add_valid", 32'(id_valid), 32'd1);
        chk("lu_add_wd", 32'(wd_o), 32'd3);
        chk("lu_add_reg1", reg1_o, 32'h77);
        chk("lu_add_reg2", reg2_o, 32'h77);
        fwd_wreg = '0;
        tick();

        // Forwarding priority on ADD x6,x5,x0 with three channel enable patterns.
        rs1_data = 32'h55; rs2_data = 32'h66;
        fwd_wd = {5'd5, 5'd5, 5'd5}; fwd_wdata = {32'hBB, 32'hCC, 32'hAA};
        for (int k = 0; k < 3; k++) begin
            logic [2:0]  en  [3];
            logic [31:0] exp [3];
            en[0] = 3'b101; exp[0] = 32'hAA;
            en[1] = 3'b110; exp[1] = 32'hCC;
            en[2] = 3'b000; exp[2] = 32'h55;
            fwd_wreg = en[k];
            push_one(32'h20, 32'h0002_8333);
            tick();
            chk($sformatf("fwd%0d_reg1", k), reg1_o, exp[k]);
            chk($sformatf("fwd%0d_reg2", k), reg2_o, 32'h0);
            tick();
        end
        fwd_wreg = '0;

        // Fill the queue while EX stalls, pop once, then flush with a concurrent push.
        ex_ready = 1'b0;
        fif.if_valid = 1'b1; fif.if_inst = 32'h0050_0093;
        for (int k = 0; k < 4; k++) begin
            fif.if_pc = 32'(k * 4);
            tick();
        end
        chk("full_if_ready", 32'(fif.if_ready), 32'd0);
        chk("full_hold_valid", 32'(id_valid), 32'd0);
        ex_ready = 1'b1;
        tick();
        chk("full_pop_valid", 32'(id_valid), 32'd1);
        chk("full_no_credit", 32'(fif.if_ready), 32'd1);
        flush = 1'b1;
        tick();
        chk("flush_valid", 32'(id_valid), 32'd0);
        chk("flush_if_ready", 32'(fif.if_ready), 32'd1);
        flush = 1'b0; fif.if_valid = 1'b0;
        tick();
        chk("flush_empty", 32'(id_valid), 32'd0);

        // JAL x1,+16 at 0x100 and the BTB write pulse.
        push_one(32'h100, 32'h0100_00EF);
        tick();
        chk("jal_valid", 32'(id_valid), 32'd1);
        chk("jal_br_t", br_t_o, 32'h110);
        chk("jal_imm", imm_o, 32'h104);
        chk("jal_b_we", 32'(b_we_o), 32'd1);
        chk("jal_b_wtarget", b_wtarget_o, 32'h110);
        chk("jal_b_waddr", b_waddr_o, 32'h100);
        tick();
        chk("jal_b_we_drop", 32'(b_we_o), 32'd0);
        chk("jal_bubble", 32'(id_valid), 32'd0);

        // Freeze with rdy=0 while fetch keeps offering an instruction.
        push_one(32'h104, 32'h0010_0013);
        rdy = 1'b0;
        fif.if_valid = 1'b1; fif.if_pc = 32'h108; fif.if_inst = 32'h0050_0093;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("frz%0d_valid", k), 32'(id_valid), 32'd0);
            chk($sformatf("frz%0d_opcode", k), 32'(opcode_o), 32'h06F);
            chk($sformatf("frz%0d_b_we", k), 32'(b_we_o), 32'd0);
        end
        rdy = 1'b1; fif.if_valid = 1'b0;
        tick();
        chk("x0_valid", 32'(id_valid), 32'd1);
        chk("x0_wreg", 32'(wreg_o), 32'd0);
        chk("x0_imm", imm_o, 32'd1);
        tick();
        chk("frz_no_push", 32'(id_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_issue_q.md
# id_issue_q

Parametrised decode/issue stage for the RV32I pipeline, sitting between IF and the ID/EX register. It buffers fetched instructions in a QDEPTH-entry queue and decodes the head. Operands are resolved through NUM_FWD forwarding channels. Load-use hazards against NUM_LDSTG downstream load stages, plus its own just-issued load, are interlocked. Each decoded micro-op is held in a registered valid/ready output slot.

## Interface
- QDEPTH, 4, instruction queue entries; power of two, ≥2
- NUM_FWD, 3, forwarding channels; index 0 = youngest, highest priority
- NUM_LDSTG, 1, downstream stages that may hold an unfinished load
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- rdy  in  1  global enable; 0 freezes all state, outputs hold
- flush  in  1  mispredict kill of queue and output slot
- if_valid / if_ready  in / out  1 / 1  fetch handshake
- if_pc, if_inst  in  32 each  fetched PC and instruction
- if_taken  in  1  predictor decision, carried to taken_o
- rs1_addr, rs2_addr  out  5 each  regfile read addresses, from the queue head
- rs1_data, rs2_data  in  32 each  regfile read data
- fwd_wreg  in  NUM_FWD  per-channel write enable
- fwd_wd  in  5*NUM_FWD  per-channel destination
- fwd_wdata  in  32*NUM_FWD  per-channel result
- ld_busy  in  NUM_LDSTG  stage holds a load whose data is not yet forwardable
- ld_rd  in  5*NUM_LDSTG  that load's destination
- ex_ready  in  1  ID/EX may accept
- id_valid  out  1  output slot holds a micro-op
- opcode_o  out  11  {inst[30], inst[14:12], inst[6:0]}
- reg1_o, reg2_o, imm_o  out  32 each  resolved operands and immediate
- wd_o  out  5  destination register
- wreg_o  out  1  write-back enable
- br_t_o, br_n_o  out  32 each  taken and not-taken targets
- taken_o  out  1  carried prediction
- b_we_o  out  1  BTB write enable; one-cycle pulse
- b_waddr_o, b_wtarget_o  out  32 each  BTB write address and target

## Operation
- Queue push: if_valid && if_ready. if_ready = (count < QDEPTH); there is no same-cycle pop credit.
- Head decode covers OP, LUI, AUIPC, OP-IMM, JAL, JALR, BRANCH, LOAD and STORE, with immediate formats per the ISA.
  - Unknown opcode issues as a NOP: opcode 0, wreg 0.
  - wreg_o is forced to 0 when rd = 0.
- Operand resolution for each source that is read:
  - source x0 gives 0;
  - otherwise the lowest-index fwd channel with wreg and a matching wd;
  - otherwise the regfile value.
- Operand defaults for sources that are not read: reg1_o = imm and reg2_o = imm.
  - AUIPC: imm = pc + {u, 12'b0}.
  - JAL and JALR: imm = pc + 4.
- JALR target = resolved rs1 + sext(imm12). The LSB is NOT cleared; EX owns that.
- Hazard condition: the head reads a nonzero rs that matches either of these:
  - any ld_busy[i] with ld_rd[i];
  - the output slot, when id_valid is set, its op is a LOAD, and its wd matches.
- Output slot update, applied only when rdy = 1:
  - ex_ready=0: hold.
  - ex_ready=1, queue nonempty, no hazard: pop the head and load the slot; id_valid=1.
  - ex_ready=1 and (empty or hazard): bubble; id_valid=0, other fields hold.
- BTB: b_we_o pulses for exactly one cycle, in the cycle after a JAL or BRANCH is loaded into the slot.
  - b_waddr_o = pc.
  - b_wtarget_o = br_t_o.
- flush (when rdy = 1):
  - count becomes 0 and the pointers reset;
  - id_valid and b_we_o become 0;
  - any if push in the same cycle is dropped.
  - flush has priority over push, pop and hold.

## Timing
- Reset, sampled at the clk edge while rst_n=0:
  - count, pointers, id_valid, b_we_o and all output fields become 0;
  - if_ready=1 from the next cycle.
- Latency: an instruction pushed at edge t can set id_valid at edge t+1 at the earliest. The queue head is combinational to decode.
- Load-use: a LOAD issued at edge t blocks a dependent head at edge t+1 through the internal check. After that it blocks through ld_busy until the stage deasserts it.
- Full queue: if_ready=0 for the whole cycle even if a pop occurs that cycle.
- Pointer wrap is modulo QDEPTH. count width is clog2(QDEPTH)+1.
- rdy=0 takes precedence over everything except reset.

## Structure
- Shared package holds:
  - RV32I opcode constants;
  - OPCODE_W=11;
  - NOP encodings;
  - the ZeroWord and NOPRegAddr constants.
- Sub-module inst_fifo, parametrised by width and depth: 65-bit entries {taken, pc, inst}, with push, pop, flush, count and head outputs.

## Test plan
- Reset, then push ADDI x1,x0,5 at pc 0x0 with ex_ready=1 -> id_valid=1 two edges after the push began, reg1_o=0, imm_o=5, wd_o=1, wreg_o=1.
- Issue LW x2,0(x1), then ADD x3,x2,x2 -> one bubble cycle (id_valid=0). Hold ld_busy[0]=1, ld_rd=2 for 2 cycles -> ADD issues the cycle after ld_busy drops.
- fwd channels 0 and 2 both target x5 with 0xAA and 0xBB, head ADD x6,x5,x0 -> reg1_o=0xAA, reg2_o=0.
- Push 4 instructions with ex_ready=0 -> if_ready=0. Raise ex_ready and flush together -> queue empty, id_valid=0, if_ready=1 next cycle.
- JAL x1,+16 at pc 0x100 -> br_t_o=0x110, imm_o=0x104, b_we_o high exactly one cycle with b_wtarget_o=0x110.
- rdy=0 mid-stream for 3 cycles with if_valid=1 -> no push, no pop, outputs stable. Also ADDI x0,x0,1 -> wreg_o=0.
